// File: rtl/se_tone.sv
// Square-wave tone generator: converts a requested frequency in Hz into a half-period
// cycle count with a restoring divider and toggles oAudio only at waveform edges.
module se_tone #(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iEnable,
    input  logic [FREQ_W-1:0] iFreq,
    output logic              oAudio,
    output logic              oActive,
    output logic              oBusy
);

    // state   | meaning
    // --------+---------------------------------------------------------
    // S_IDLE  | output parked low, divider cleared, waiting for a request
    // S_START | first divide in flight, waiting for pend_valid
    // S_RUN   | square wave running, half-period from half_q
    // S_DRAIN | request dropped while high; finish the high level, then idle
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int               ITW       = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] DIV       = CNT_W'(CLK_HZ / 2);
    localparam logic [ITW-1:0]   ITER_INIT = ITW'(CNT_W);

    logic [1:0]        state_q, state_d;
    logic              audio_q, audio_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [CNT_W-1:0]  pend_half_q, pend_half_d;
    logic              pend_valid_q, pend_valid_d;
    logic [FREQ_W-1:0] last_freq_q, last_freq_d;
    logic              busy_q, busy_d;
    logic [ITW-1:0]    iter_q, iter_d;
    logic [FREQ_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]  quo_q, quo_d;

    logic              req;
    logic              div_start;
    logic              div_done;
    logic              tc;
    logic              pend_clr;
    logic              go_idle;
    logic [FREQ_W:0]   rem_sh;
    logic              rem_ge;
    logic [CNT_W-1:0]  quo_next;
    logic [CNT_W-1:0]  h_calc;

    assign req       = iEnable && (iFreq != '0);
    assign div_start = !busy_q && req && (iFreq != last_freq_q);
    assign div_done  = busy_q && (iter_q == ITW'(1));
    assign tc        = (cnt_q == (half_q - CNT_W'(1)));

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh   = {rem_q, quo_q[CNT_W-1]};
    assign rem_ge   = (rem_sh >= {1'b0, last_freq_q});
    assign quo_next = {quo_q[CNT_W-2:0], rem_ge};
    assign h_calc   = (quo_next == '0) ? CNT_W'(1) : quo_next;

    always_comb begin
        state_d  = state_q;
        audio_d  = audio_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        pend_clr = 1'b0;
        go_idle  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                audio_d = 1'b0;
                if (div_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (!req) begin
                    go_idle = 1'b1;
                end else if (pend_valid_q) begin
                    half_d   = pend_half_q;
                    pend_clr = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            default: begin
                if (tc) begin
                    audio_d = !audio_q;
                    cnt_d   = '0;
                    if (pend_valid_q) begin
                        half_d   = pend_half_q;
                        pend_clr = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // The toggle is resolved first, so a terminal count that lands low ends the tone.
                if (req) begin
                    state_d = S_RUN;
                end else if (audio_d) begin
                    state_d = S_DRAIN;
                end else begin
                    go_idle = 1'b1;
                end
            end
        endcase
        if (go_idle) begin
            state_d = S_IDLE;
            audio_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_comb begin
        busy_d       = busy_q;
        iter_d       = iter_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        last_freq_d  = last_freq_q;
        pend_half_d  = pend_half_q;
        pend_valid_d = pend_clr ? 1'b0 : pend_valid_q;
        if (busy_q) begin
            rem_d  = rem_ge ? FREQ_W'(rem_sh - {1'b0, last_freq_q}) : rem_sh[FREQ_W-1:0];
            quo_d  = quo_next;
            iter_d = iter_q - ITW'(1);
            if (div_done) begin
                busy_d       = 1'b0;
                pend_valid_d = 1'b1;
                pend_half_d  = h_calc;
            end
        end else if (div_start) begin
            busy_d      = 1'b1;
            iter_d      = ITER_INIT;
            rem_d       = '0;
            quo_d       = DIV;
            last_freq_d = iFreq;
        end
        // Clearing last_freq forces a fresh divide on the next trigger, even at the same frequency.
        if (go_idle) begin
            busy_d       = 1'b0;
            pend_valid_d = 1'b0;
            last_freq_d  = '0;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_q      <= S_IDLE;
            audio_q      <= 1'b0;
            cnt_q        <= '0;
            half_q       <= '0;
            pend_half_q  <= '0;
            pend_valid_q <= 1'b0;
            last_freq_q  <= '0;
            busy_q       <= 1'b0;
            iter_q       <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
        end else begin
            state_q      <= state_d;
            audio_q      <= audio_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_half_q  <= pend_half_d;
            pend_valid_q <= pend_valid_d;
            last_freq_q  <= last_freq_d;
            busy_q       <= busy_d;
            iter_q       <= iter_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
        end
    end

    assign oAudio  = audio_q;
    assign oActive = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign oBusy   = busy_q;

endmodule
